alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequencing controller for the 8-bit ALU datapath. It arbitrates between two requesters with round-robin priority and executes single-cycle ops (add, sub, xor, and, or, logical and/or) in one execute cycle. Multiply runs as a multi-cycle shift-add over WIDTH cycles, one multiplier bit per cycle, and produces a full double-width product. It sits between the command sources and the ALU result consumers and returns a tagged, pulsed completion.

Parameters:
WIDTH, 8, operand width; also the multiply iteration count.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  global stall; 0 freezes all state and outputs.
req0  input  1  requester 0 command valid; held until ack0.
opc0  input  8  requester 0 opcode.
a0  input  WIDTH  requester 0 operand A.
b0  input  WIDTH  requester 0 operand B.
req1  input  1  requester 1 command valid; held until ack1.
opc1  input  8  requester 1 opcode.
a1  input  WIDTH  requester 1 operand A.
b1  input  WIDTH  requester 1 operand B.
ack0  output  1  one-cycle pulse: requester 0 command accepted.
ack1  output  1  one-cycle pulse: requester 1 command accepted.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse: result valid.
done_id  output  1  requester that owns the current result.
z  output  WIDTH  result low word.
zhi  output  WIDTH  multiply high word; ADD carry in bit 0; SUB borrow in bit 0; 0 otherwise.
err  output  1  illegal opcode flag; valid with done.

Behaviour:
- Reset, applied on any clock edge and overriding enable: state goes to IDLE; ack0, ack1, busy, done, done_id, err, z, zhi all go to 0; the round-robin pointer resets so req0 wins the next tie.
- When enable=0, no register updates. Outputs hold their values, so an active done or ack stays high until the first enabled cycle.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE: on an edge where req0 or req1 is sampled high, grant one requester, latch its opc, a and b, and register its ack high for the next cycle.
  - Next state is MUL if opc=0x02; otherwise EXEC.
  - With no request, stay in IDLE.
- Arbitration: a single requester always wins. If both request, the winner is the requester not granted last; the pointer updates on each grant.
- EXEC (one cycle): compute the result into z, zhi and err, then go to DONE.
  - 0x00: z = a+b mod 2^WIDTH; zhi[0] = carry.
  - 0x01: z = a-b mod 2^WIDTH; zhi[0] = borrow (a<b).
  - 0x03: xor. 0x04: and. 0x05: or.
  - 0x06: z = (a!=0 && b!=0), giving 1 or 0. 0x07: z = (a!=0 || b!=0).
  - Any other opcode: z=0, zhi=0, err=1.
- MUL: 2*WIDTH-bit accumulator and shifted multiplicand, both cleared or loaded on the grant edge; iteration counter runs 0..WIDTH-1.
  - Each cycle: if b[i], add the shifted multiplicand to the accumulator; then shift the multiplicand left by 1.
  - After iteration WIDTH-1, go to DONE with {zhi,z} = a*b and err=0.
- DONE (one cycle): done=1, done_id = granted requester; next state is IDLE. No grant is made in DONE.
- z, zhi, err and done_id hold their values until the next DONE or reset.
- Latency, with the grant on edge E0: ack is high in the cycle after E0. For single-cycle ops done is high 2 cycles after E0; for MUL, WIDTH+1 cycles after E0 (9 at WIDTH=8). Throughput is one command per 3 cycles (single-cycle ops) or WIDTH+2 cycles (MUL).
- Requester rule: drop req in the cycle ack is seen. A req still high when IDLE is re-entered is treated as a new command.
- Reset during EXEC, MUL or DONE aborts the operation: no done, no further ack, and latched operands are discarded.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: OP_ADD=0x00, OP_SUB=0x01, OP_MUL=0x02, OP_XOR=0x03, OP_AND=0x04, OP_OR=0x05, OP_LAND=0x06, OP_LOR=0x07;
  - state encoding IDLE, EXEC, MUL, DONE;
  - requester id constants.
- One sub-module, rr_arb2: 2-way round-robin arbiter with clock, reset and enable, inputs req[1:0] and an advance strobe, output a one-hot grant.
- The multiply iteration and the EXEC ALU stay inline.

Test Plan:
- ADD from req0, a=200, b=100 -> ack0 high 1 cycle after the grant edge; done 2 cycles after it with z=44, zhi=0x01, err=0, done_id=0.
- MUL from req1, a=13, b=11 -> done 9 cycles after the grant edge with z=0x8F, zhi=0x00, done_id=1. Repeat with 255*255 -> z=0x01, zhi=0xFE.
- req0 (SUB 5-7) and req1 (XOR 0xF0,0x3C) asserted in the same cycle after reset -> req0 served first: z=0xFE, zhi=0x01. req1 is served next: z=0xCC, done_id=1. A further simultaneous request pair is then granted to req0.
- Illegal opcode 0x09 -> done with z=0, zhi=0, err=1; a following AND 0xAA,0x0F gives z=0x0A with err=0.
- Reset asserted during the 4th MUL iteration -> next cycle busy=0 and z=0; no done ever pulses for that command. Then ADD 1+1 gives z=2.
- enable=0 for 3 cycles during MUL and again while done=1 -> completion delayed exactly 3 cycles; done stays high across the stall and drops one enabled cycle later; the result is unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, sequencer state encoding and requester ids
//               for the ALU sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes
    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_LAND = 8'h06;
    localparam logic [7:0] OP_LOR  = 8'h07;

    // Sequencer states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Requester identifiers as reported on done_id
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               on a tie the requester not granted last wins. The pointer
//               moves only when the caller signals that the grant was taken.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Id of the requester granted most recently
    logic r_last;

    // One-hot grant from the current requests and the round-robin pointer
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last == REQ_ID1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Pointer update on an accepted grant; reset favours requester 0 on a tie
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= REQ_ID1;
        end else if (enable && i_advance && (|o_grant)) begin
            r_last <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequencing controller for the ALU datapath. Grants one of two
//               requesters, runs single-cycle ops in one EXEC cycle or a
//               WIDTH-cycle shift-add multiply, then pulses a tagged done.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             req0,
    input  logic [7:0]       opc0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [7:0]       opc1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] zhi,
    output logic             err
);

    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    state_t               r_state;
    logic                 r_id;
    logic [7:0]           r_opc;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [c_CW-1:0]      r_cnt;

    logic [1:0]           w_req;
    logic [1:0]           w_grant;
    logic                 w_adv;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_z;
    logic [WIDTH-1:0]     w_zhi;
    logic                 w_err;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_req = {req1, req0};
    assign w_adv = (r_state == ST_IDLE) && (|w_req);
    assign busy  = (r_state != ST_IDLE);

    rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .i_req     (w_req),
        .i_advance (w_adv),
        .o_grant   (w_grant)
    );

    // Single-cycle ALU on the latched operands; unknown opcodes flag err
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        w_z    = '0;
        w_zhi  = '0;
        w_err  = 1'b0;
        case (r_opc)
            OP_ADD: begin
                w_z   = w_sum[WIDTH-1:0];
                w_zhi = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            end
            OP_SUB: begin
                w_z   = w_diff[WIDTH-1:0];
                w_zhi = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
            end
            OP_XOR:  w_z = r_a ^ r_b;
            OP_AND:  w_z = r_a & r_b;
            OP_OR:   w_z = r_a | r_b;
            OP_LAND: w_z = {{(WIDTH-1){1'b0}}, ((r_a != '0) && (r_b != '0))};
            OP_LOR:  w_z = {{(WIDTH-1){1'b0}}, ((r_a != '0) || (r_b != '0))};
            default: w_err = 1'b1;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when multiplier bit is set
    always_comb begin
        w_acc_next = r_b[r_cnt] ? (r_acc + r_mcand) : r_acc;
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_id    <= REQ_ID0;
            r_opc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            z       <= '0;
            zhi     <= '0;
            err     <= 1'b0;
        end else if (enable) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        ack0    <= w_grant[0];
                        ack1    <= w_grant[1];
                        r_id    <= w_grant[1];
                        r_opc   <= w_grant[1] ? opc1 : opc0;
                        r_a     <= w_grant[1] ? a1 : a0;
                        r_b     <= w_grant[1] ? b1 : b0;
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, (w_grant[1] ? a1 : a0)};
                        r_cnt   <= '0;
                        r_state <= ((w_grant[1] ? opc1 : opc0) == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    z       <= w_z;
                    zhi     <= w_zhi;
                    err     <= w_err;
                    done    <= 1'b1;
                    done_id <= r_id;
                    r_state <= ST_DONE;
                end
                ST_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        z       <= w_acc_next[WIDTH-1:0];
                        zhi     <= w_acc_next[2*WIDTH-1:WIDTH];
                        err     <= 1'b0;
                        done    <= 1'b1;
                        done_id <= r_id;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed self-checking bench for alu_seq_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             req0;
    logic [7:0]       opc0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [7:0]       opc1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] zhi;
    logic             err;

    int checks   = 0;
    int failures = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .req0    (req0),
        .opc0    (opc0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .opc1    (opc1),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .z       (z),
        .zhi     (zhi),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present a command on one requester and take the grant edge
    task automatic issue(input logic id, input logic [7:0] opc,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id) begin
            req1 = 1'b1; opc1 = opc; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; opc0 = opc; a0 = a; b0 = b;
        end
        tick();
    endtask

    // Edges taken until done is seen (bounded); -1 when it never arrives
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack0, ack1, busy, done, done_id, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {ack0, ack1, busy, done, done_id, err});
        end
        checks++;
        if ({zhi, z} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0000", {zhi, z});
        end
        tick();
        checks++;
        if ({busy, ack0, ack1} !== 3'b000) begin
            failures++;
            $display("FAIL idle_no_req got=%b exp=000", {busy, ack0, ack1});
        end
    endtask

    task automatic test_add();
        int n;
        issue(1'b0, 8'h00, 8'd200, 8'd100);
        checks++;
        if ({ack0, ack1, busy, done} !== 4'b1010) begin
            failures++;
            $display("FAIL add_ack got=%b exp=1010", {ack0, ack1, busy, done});
        end
        req0 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", n); end
        checks++;
        if ({zhi, z, err, done_id, ack0} !== {8'h01, 8'd44, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_result got=%h/%h err=%b id=%b exp=01/2c err=0 id=0", zhi, z, err, done_id);
        end
        tick();
        checks++;
        if ({done, busy, z} !== {1'b0, 1'b0, 8'd44}) begin
            failures++;
            $display("FAIL add_after got done=%b busy=%b z=%h exp 0 0 2c", done, busy, z);
        end
    endtask

    task automatic test_mul();
        int n;
        issue(1'b1, 8'h02, 8'd13, 8'd11);
        checks++;
        if ({ack0, ack1} !== 2'b01) begin
            failures++;
            $display("FAIL mul_ack got=%b exp=01", {ack0, ack1});
        end
        req1 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 8) begin failures++; $display("FAIL mul_latency got=%0d exp=8", n); end
        checks++;
        if ({zhi, z, err, done_id} !== {16'h008F, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mul_13x11 got=%h%h err=%b id=%b exp=008f 0 1", zhi, z, err, done_id);
        end
        tick();
        issue(1'b1, 8'h02, 8'd255, 8'd255);
        req1 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 8 || {zhi, z} !== 16'hFE01) begin
            failures++;
            $display("FAIL mul_255x255 got n=%0d %h%h exp n=8 fe01", n, zhi, z);
        end
        tick();
    endtask

    task automatic test_arbitration();
        int n;
        do_reset();
        req0 = 1'b1; opc0 = 8'h01; a0 = 8'd5;   b0 = 8'd7;
        req1 = 1'b1; opc1 = 8'h03; a1 = 8'hF0;  b1 = 8'h3C;
        tick();
        checks++;
        if ({ack0, ack1} !== 2'b10) begin
            failures++;
            $display("FAIL arb_first got=%b exp=10", {ack0, ack1});
        end
        req0 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 || {zhi, z, done_id} !== {8'h01, 8'hFE, 1'b0}) begin
            failures++;
            $display("FAIL arb_sub got n=%0d %h/%h id=%b exp n=1 01/fe id=0", n, zhi, z, done_id);
        end
        tick();
        tick();
        checks++;
        if ({ack0, ack1} !== 2'b01) begin
            failures++;
            $display("FAIL arb_second got=%b exp=01", {ack0, ack1});
        end
        req1 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 || {zhi, z, done_id} !== {8'h00, 8'hCC, 1'b1}) begin
            failures++;
            $display("FAIL arb_xor got n=%0d %h/%h id=%b exp n=1 00/cc id=1", n, zhi, z, done_id);
        end
        tick();
        req0 = 1'b1; opc0 = 8'h05; a0 = 8'h01; b0 = 8'h02;
        req1 = 1'b1; opc1 = 8'h04; a1 = 8'h01; b1 = 8'h02;
        tick();
        checks++;
        if ({ack0, ack1} !== 2'b10) begin
            failures++;
            $display("FAIL arb_third got=%b exp=10", {ack0, ack1});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(n);
        checks++;
        if ({z, done_id} !== {8'h03, 1'b0}) begin
            failures++;
            $display("FAIL arb_or got z=%h id=%b exp 03 0", z, done_id);
        end
        tick();
    endtask

    task automatic test_illegal();
        int n;
        issue(1'b0, 8'h09, 8'h12, 8'h34);
        req0 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 || {zhi, z, err} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL illegal got n=%0d %h%h err=%b exp n=1 0000 err=1", n, zhi, z, err);
        end
        tick();
        issue(1'b0, 8'h04, 8'hAA, 8'h0F);
        req0 = 1'b0;
        wait_done(n);
        checks++;
        if ({zhi, z, err} !== {8'h00, 8'h0A, 1'b0}) begin
            failures++;
            $display("FAIL and_after_illegal got %h/%h err=%b exp 00/0a err=0", zhi, z, err);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  seen;
        issue(1'b0, 8'h02, 8'd5, 8'd6);
        req0 = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, z} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL abort_state got busy=%b done=%b z=%h exp 0 0 00", busy, done, z);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0 || ack0 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=1 exp=0");
        end
        issue(1'b0, 8'h00, 8'd1, 8'd1);
        req0 = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 1 || z !== 8'd2) begin
            failures++;
            $display("FAIL add_after_abort got n=%0d z=%h exp n=1 02", n, z);
        end
        tick();
    endtask

    task automatic test_stall();
        int n;
        bit ok;
        issue(1'b0, 8'h02, 8'd7, 8'd9);
        req0 = 1'b0;
        tick(); tick();
        enable = 1'b0;
        tick(); tick(); tick();
        enable = 1'b1;
        wait_done(n);
        checks++;
        if (n !== 6 || {zhi, z} !== 16'd63) begin
            failures++;
            $display("FAIL stall_mul got n=%0d %h%h exp n=6 003f", n, zhi, z);
        end
        enable = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b1 || z !== 8'd63 || busy !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_done_hold got done=%b z=%h exp 1 3f", done, z);
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({done, busy, zhi, z} !== {1'b0, 1'b0, 16'd63}) begin
            failures++;
            $display("FAIL stall_release got done=%b busy=%b %h%h exp 0 0 003f", done, busy, zhi, z);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        req0 = 1'b0; opc0 = 8'h00; a0 = '0; b0 = '0;
        req1 = 1'b0; opc1 = 8'h00; a1 = '0; b1 = '0;
        test_reset();
        test_add();
        test_mul();
        test_arbitration();
        test_illegal();
        test_reset_abort();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
